// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core: stall/flush sequencing,
// EX operand forwarding selects and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int REG_AW  = 3,
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mul,
  input  logic              ex_branch_taken,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              mem_reg_write,
  input  logic              wb_reg_write,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_en,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_mem_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mul_busy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [0:0] {RUN = 1'b0, MUL_WAIT = 1'b1} state_t;

  localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};
  localparam logic [3:0]        MUL_LOAD = 4'(MUL_LAT - 2);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  state_t            state_r, state_nxt_s;
  logic [3:0]        mul_cnt_r, mul_cnt_nxt_s;
  logic [REG_AW-1:0] ex_rs1_r, ex_rs2_r;
  logic [CNT_W-1:0]  stall_cnt_r;
  logic              load_use_s;
  logic              pc_en_s, if_id_en_s, id_ex_en_s;
  logic              if_id_flush_s, id_ex_flush_s, ex_mem_flush_s, mul_busy_s;

  // MEM result wins over WB; r0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] m_rd,
    input logic              m_we,
    input logic [REG_AW-1:0] w_rd,
    input logic              w_we
  );
    logic [1:0] sel;
    if (m_we && (m_rd != REG_ZERO) && (m_rd == rs)) begin
      sel = 2'b01;
    end else if (w_we && (w_rd != REG_ZERO) && (w_rd == rs)) begin
      sel = 2'b10;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Load in EX whose destination is read by the instruction in ID.
  always_comb begin
    load_use_s = ex_mem_read && (ex_rd != REG_ZERO) &&
                 ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
  end

  // Next-state and ungated control: branch beats multiply beats load-use.
  always_comb begin
    state_nxt_s    = state_r;
    mul_cnt_nxt_s  = mul_cnt_r;
    pc_en_s        = 1'b1;
    if_id_en_s     = 1'b1;
    id_ex_en_s     = 1'b1;
    if_id_flush_s  = 1'b0;
    id_ex_flush_s  = 1'b0;
    ex_mem_flush_s = 1'b0;
    mul_busy_s     = 1'b0;
    case (state_r)
      RUN: begin
        if (ex_branch_taken) begin
          if_id_flush_s = 1'b1;
          id_ex_flush_s = 1'b1;
        end else if (ex_mul) begin
          state_nxt_s    = MUL_WAIT;
          mul_cnt_nxt_s  = MUL_LOAD;
          pc_en_s        = 1'b0;
          if_id_en_s     = 1'b0;
          id_ex_en_s     = 1'b0;
          ex_mem_flush_s = 1'b1;
          mul_busy_s     = 1'b1;
        end else if (load_use_s) begin
          pc_en_s       = 1'b0;
          if_id_en_s    = 1'b0;
          id_ex_flush_s = 1'b1;
        end else begin
          state_nxt_s = RUN;
        end
      end
      MUL_WAIT: begin
        if (mul_cnt_r == 4'd0) begin
          // Exit cycle: product advances; ID hazards are honoured, ex_mul is not.
          state_nxt_s = RUN;
          if (ex_branch_taken) begin
            if_id_flush_s = 1'b1;
            id_ex_flush_s = 1'b1;
          end else if (load_use_s) begin
            pc_en_s       = 1'b0;
            if_id_en_s    = 1'b0;
            id_ex_flush_s = 1'b1;
          end else begin
            pc_en_s = 1'b1;
          end
        end else begin
          mul_cnt_nxt_s  = mul_cnt_r - 4'd1;
          pc_en_s        = 1'b0;
          if_id_en_s     = 1'b0;
          id_ex_en_s     = 1'b0;
          ex_mem_flush_s = 1'b1;
          mul_busy_s     = 1'b1;
        end
      end
      default: begin
        state_nxt_s   = RUN;
        mul_cnt_nxt_s = 4'd0;
      end
    endcase
  end

  // Output stage: while reset is low the whole pipeline is held and flushed.
  always_comb begin
    if (!reset) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mul_busy     = 1'b0;
      fwd_a        = 2'b00;
      fwd_b        = 2'b00;
    end else begin
      pc_en        = pc_en_s;
      if_id_en     = if_id_en_s;
      id_ex_en     = id_ex_en_s;
      if_id_flush  = if_id_flush_s;
      id_ex_flush  = id_ex_flush_s;
      ex_mem_flush = ex_mem_flush_s;
      mul_busy     = mul_busy_s;
      fwd_a        = fwd_sel(ex_rs1_r, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
      fwd_b        = fwd_sel(ex_rs2_r, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
    end
  end

  // State, multiply countdown, EX source copies and stall counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= RUN;
      mul_cnt_r   <= 4'd0;
      ex_rs1_r    <= REG_ZERO;
      ex_rs2_r    <= REG_ZERO;
      stall_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      mul_cnt_r <= mul_cnt_nxt_s;
      if (id_ex_flush_s) begin
        ex_rs1_r <= REG_ZERO;
        ex_rs2_r <= REG_ZERO;
      end else if (id_ex_en_s) begin
        ex_rs1_r <= id_rs1;
        ex_rs2_r <= id_rs2;
      end else begin
        ex_rs1_r <= ex_rs1_r;
        ex_rs2_r <= ex_rs2_r;
      end
      if (!pc_en_s && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign stall_cnt = stall_cnt_r;

endmodule
